// File: rtl/sample_player_pkg.sv
// Shared types and helpers for the sample_player clip-playback engine.
package sample_player_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StAdvance
    } state_t;

    // Widest channel word the helper below can produce.
    localparam int unsigned MaxW = 64;

    // Place a data_w-bit sample in the top bits of an out_w-bit word, zero-filling below.
    function automatic logic [MaxW-1:0] left_justify(input logic [MaxW-1:0] sample,
                                                     input int unsigned     data_w,
                                                     input int unsigned     out_w);
        return sample << (out_w - data_w);
    endfunction

endpackage

// File: rtl/sp_addr_gen.sv
// Clip address generator: latches base/len/loop, tracks the sample index and memory address.
module sp_addr_gen
    import sample_player_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              loop_in,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W-1:0] len_in,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last,
    output logic              wrap_ok
);

    localparam logic [ADDR_W-1:0] One = ADDR_W'(1);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              loop_q, loop_d;

    assign addr    = addr_q;
    assign at_last = (idx_q == (len_q - One));
    assign wrap_ok = at_last && loop_q;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        idx_d  = idx_q;
        addr_d = addr_q;
        loop_d = loop_q;
        if (load) begin
            base_d = base_in;
            len_d  = len_in;
            loop_d = loop_in;
            idx_d  = '0;
            addr_d = base_in;
        end else if (step) begin
            if (!at_last) begin
                idx_d  = idx_q + One;
                // Address wraps freely at the top of memory.
                addr_d = addr_q + One;
            end else if (loop_q) begin
                idx_d  = '0;
                addr_d = base_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            addr_q <= '0;
            loop_q <= 1'b0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
            addr_q <= addr_d;
            loop_q <= loop_d;
        end
    end

endmodule

// File: rtl/sample_player.sv
// Clip playback engine: fetches samples from memory and feeds them to the audio output FIFO,
// advancing only on the FIFO handshake, with optional looping and per-sample repeat.
module sample_player
    import sample_player_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned OUT_W   = 32,
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned RPT_W   = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] clip_base,
    input  logic [ADDR_W-1:0] clip_len,
    input  logic              loop_en,
    input  logic [RPT_W-1:0]  repeat_n,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [OUT_W-1:0]  left_channel_audio_out,
    output logic [OUT_W-1:0]  right_channel_audio_out,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0]       LatCnt = 2'(RAM_LAT);
    localparam logic [RPT_W-1:0] RptOne = RPT_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic [RPT_W-1:0]  rptn_q, rptn_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              done_q, done_d;
    logic              load;
    logic              step;
    logic              write_c;
    logic              at_last;
    logic              wrap_ok;

    sp_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (CLOCK_50),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .loop_in (loop_en),
        .base_in (clip_base),
        .len_in  (clip_len),
        .addr    (ram_addr),
        .at_last (at_last),
        .wrap_ok (wrap_ok)
    );

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        rpt_d    = rpt_q;
        rptn_d   = rptn_q;
        sample_d = sample_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        write_c  = 1'b0;

        if (stop) begin
            state_d  = StIdle;
            wait_d   = '0;
            rpt_d    = '0;
            sample_d = '0;
        end else if (start && (clip_len != '0)) begin
            state_d = StFetch;
            load    = 1'b1;
            rptn_d  = repeat_n;
            wait_d  = '0;
            rpt_d   = '0;
            // A retrigger abandons the held sample; only idle zero-feeding may continue.
            write_c = (state_q == StIdle) && audio_out_allowed;
        end else begin
            unique case (state_q)
                StIdle: begin
                    write_c = audio_out_allowed;
                end
                StFetch: begin
                    if (wait_q == LatCnt) begin
                        sample_d = ram_q;
                        wait_d   = '0;
                        state_d  = StHold;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                StHold: begin
                    if (audio_out_allowed) begin
                        write_c = 1'b1;
                        if (rpt_q == rptn_q) begin
                            rpt_d   = '0;
                            state_d = StAdvance;
                        end else begin
                            rpt_d = rpt_q + RptOne;
                        end
                    end
                end
                StAdvance: begin
                    step = 1'b1;
                    if (at_last && !wrap_ok) begin
                        state_d  = StIdle;
                        done_d   = 1'b1;
                        sample_d = '0;
                    end else begin
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (reset) begin
            write_c = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= StIdle;
            wait_q   <= '0;
            rpt_q    <= '0;
            rptn_q   <= '0;
            sample_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rpt_q    <= rpt_d;
            rptn_q   <= rptn_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign busy                    = (state_q != StIdle);
    assign done                    = done_q;
    assign write_audio_out         = write_c;
    assign left_channel_audio_out  = OUT_W'(left_justify(MaxW'(sample_q), DATA_W, OUT_W));
    assign right_channel_audio_out = left_channel_audio_out;

endmodule

// File: tb/tb_sample_player.sv
// Self-checking bench for sample_player: memory model with latency, handshake patterns,
// and a clip-level reference model of the expected write stream.
module tb_sample_player;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned RAM_LAT = 2;
    localparam int unsigned RPT_W   = 4;
    localparam int          Depth   = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] clip_base;
    logic [ADDR_W-1:0] clip_len;
    logic              loop_en;
    logic [RPT_W-1:0]  repeat_n;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;
    logic              allowed;
    logic              write_audio_out;
    logic [OUT_W-1:0]  left;
    logic [OUT_W-1:0]  right;
    logic              busy;
    logic              done;

    sample_player #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .RAM_LAT (RAM_LAT),
        .RPT_W   (RPT_W)
    ) dut (
        .CLOCK_50                (clk),
        .reset                   (reset),
        .start                   (start),
        .stop                    (stop),
        .clip_base               (clip_base),
        .clip_len                (clip_len),
        .loop_en                 (loop_en),
        .repeat_n                (repeat_n),
        .ram_addr                (ram_addr),
        .ram_q                   (ram_q),
        .audio_out_allowed       (allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left),
        .right_channel_audio_out (right),
        .busy                    (busy),
        .done                    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] mem [Depth];

    // Memory model: data for an address appears RAM_LAT cycles later.
    logic [DATA_W-1:0] p0, p1;
    logic [ADDR_W-1:0] a_s;
    initial begin
        ram_q = '0;
        p0 = '0;
        p1 = '0;
        forever begin
            @(negedge clk);
            a_s = ram_addr;
            @(posedge clk);
            #1;
            p1 = p0;
            p0 = mem[a_s];
            ram_q = (RAM_LAT == 1) ? p0 : p1;
        end
    end

    // 0: always allowed, 1: one cycle in four, 2: random, other: never
    int allow_mode = 3;
    int phase = 0;
    initial begin
        allowed = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (allow_mode)
                0: allowed = 1'b1;
                1: begin
                    allowed = (phase == 0);
                    phase = (phase + 1) % 4;
                end
                2: allowed = 1'($urandom_range(0, 1));
                default: allowed = 1'b0;
            endcase
        end
    end

    // Monitor: records every write made while busy, plus protocol counters.
    int               cyc = 0;
    int               start_cyc = 0;
    int               viol = 0;
    int               stop_wr = 0;
    int               chan_mis = 0;
    int               idle_wr = 0;
    int               idle_bad = 0;
    int               done_cnt = 0;
    int               done_busy = 0;
    logic [OUT_W-1:0] wq_data [$];
    int               wq_addr [$];
    int               wq_cyc  [$];

    always @(negedge clk) begin
        cyc++;
        if (start) start_cyc = cyc;
        if (write_audio_out) begin
            if (!allowed) viol++;
            if (stop) stop_wr++;
            if (right !== left) chan_mis++;
            if (busy) begin
                wq_data.push_back(left);
                wq_addr.push_back(int'(ram_addr));
                wq_cyc.push_back(cyc);
            end else begin
                idle_wr++;
                if (left !== '0) idle_bad++;
            end
        end
        if (done) begin
            done_cnt++;
            if (busy) done_busy++;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish within time limit");
        $fatal(1, "timeout");
    end

    logic [OUT_W-1:0] exp_d [$];
    int               exp_a [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: write k plays clip sample (k / (rpt+1)) mod len, address wrapping at Depth.
    function automatic void ref_clip(input int base, input int len, input int rpt, input int n);
        int i;
        int a;
        exp_d.delete();
        exp_a.delete();
        for (int k = 0; k < n; k++) begin
            i = (k / (rpt + 1)) % len;
            a = (base + i) % Depth;
            exp_a.push_back(a);
            exp_d.push_back(OUT_W'(mem[a]) << (OUT_W - DATA_W));
        end
    endfunction

    task automatic cmp_clip(input string tag, input int qb, input int n, input bit exact);
        if (exact) check({tag, "_count"}, 64'(wq_data.size() - qb), 64'(n));
        else check({tag, "_count"}, 64'(wq_data.size() - qb >= n), 64'd1);
        for (int k = 0; k < n; k++) begin
            if (qb + k < wq_data.size()) begin
                check($sformatf("%s_d%0d", tag, k), 64'(wq_data[qb+k]), 64'(exp_d[k]));
                check($sformatf("%s_a%0d", tag, k), 64'(wq_addr[qb+k]), 64'(exp_a[k]));
            end
        end
    endtask

    task automatic start_clip(input int base, input int len, input bit lp, input int rpt);
        clip_base = ADDR_W'(base);
        clip_len  = ADDR_W'(len);
        loop_en   = lp;
        repeat_n  = RPT_W'(rpt);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        clip_base = ADDR_W'($urandom);
        clip_len  = ADDR_W'($urandom);
        loop_en   = 1'($urandom);
        repeat_n  = RPT_W'($urandom);
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(busy), 64'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_writes(input string tag, input int target);
        int n = 0;
        while (wq_data.size() < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(wq_data.size() >= target), 64'd1);
    endtask

    initial begin
        int qb;
        int qb2;
        int s_done;
        int s_idle;
        int b;
        int l;
        int r;

        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        clip_base = '0;
        clip_len = '0;
        loop_en = 1'b0;
        repeat_n = '0;
        for (int i = 0; i < Depth; i++) mem[i] = DATA_W'(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_write", 64'(write_audio_out), 64'd0);
        check("rst_left", 64'(left), 64'd0);
        check("rst_right", 64'(right), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        allow_mode = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_write_allowed", 64'(write_audio_out), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_feed_write", 64'(write_audio_out), 64'd1);
        check("idle_feed_zero", 64'(left), 64'd0);

        // One-shot, data equals address
        @(posedge clk);
        #1;
        qb = wq_data.size();
        s_done = done_cnt;
        start_clip(100, 3, 1'b0, 0);
        wait_idle("os_finish");
        ref_clip(100, 3, 0, 3);
        cmp_clip("os", qb, 3, 1'b1);
        check("os_done_once", 64'(done_cnt - s_done), 64'd1);
        check("os_done_busy", 64'(done_busy), 64'd0);
        check("os_latency", 64'(wq_cyc[qb] - start_cyc), 64'(2 + RAM_LAT));
        s_idle = idle_wr;
        repeat (5) @(negedge clk);
        #1;
        check("os_idle_writes", 64'(idle_wr - s_idle), 64'd5);
        check("os_idle_zero", 64'(idle_bad), 64'd0);

        // Loop with repeat, random memory
        for (int i = 0; i < Depth; i++) mem[i] = DATA_W'($urandom);
        @(posedge clk);
        #1;
        qb = wq_data.size();
        s_done = done_cnt;
        start_clip(0, 2, 1'b1, 2);
        wait_writes("lp_reach", qb + 9);
        stop_pulse();
        @(negedge clk);
        #1;
        check("lp_stop_busy", 64'(busy), 64'd0);
        check("lp_stop_zero", 64'(left), 64'd0);
        ref_clip(0, 2, 2, 9);
        cmp_clip("lp", qb, 9, 1'b0);
        check("lp_no_done", 64'(done_cnt - s_done), 64'd0);
        check("lp_stop_write", 64'(stop_wr), 64'd0);

        // Sparse handshake, data equals address
        for (int i = 0; i < Depth; i++) mem[i] = DATA_W'(i);
        allow_mode = 1;
        @(posedge clk);
        #1;
        qb = wq_data.size();
        s_done = done_cnt;
        start_clip(5, 4, 1'b0, 0);
        wait_idle("hs_finish");
        ref_clip(5, 4, 0, 4);
        cmp_clip("hs", qb, 4, 1'b1);
        check("hs_done", 64'(done_cnt - s_done), 64'd1);
        check("hs_allowed_only", 64'(viol), 64'd0);

        // Address wrap at top of memory, random handshake and repeat
        for (int i = 0; i < Depth; i++) mem[i] = DATA_W'($urandom);
        allow_mode = 2;
        r = $urandom_range(0, 2);
        @(posedge clk);
        #1;
        qb = wq_data.size();
        s_done = done_cnt;
        start_clip(Depth - 2, 4, 1'b0, r);
        wait_idle("wr_finish");
        ref_clip(Depth - 2, 4, r, 4 * (r + 1));
        cmp_clip("wr", qb, 4 * (r + 1), 1'b1);
        check("wr_done", 64'(done_cnt - s_done), 64'd1);
        check("wr_allowed_only", 64'(viol), 64'd0);

        // Stop mid-hold
        allow_mode = 0;
        @(posedge clk);
        #1;
        qb = wq_data.size();
        s_done = done_cnt;
        start_clip(300, 4, 1'b0, 15);
        wait_writes("ab_reach", qb + 1);
        stop_pulse();
        @(negedge clk);
        #1;
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_zero", 64'(left), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("ab_no_done", 64'(done_cnt - s_done), 64'd0);

        // Retrigger while busy
        @(posedge clk);
        #1;
        qb = wq_data.size();
        s_done = done_cnt;
        start_clip(200, 5, 1'b0, 3);
        wait_writes("rt_reach", qb + 2);
        qb2 = wq_data.size();
        start_clip(50, 2, 1'b0, 0);
        check("rt_addr", 64'(ram_addr), 64'd50);
        wait_idle("rt_finish");
        ref_clip(50, 2, 0, 2);
        cmp_clip("rt", qb2, 2, 1'b1);
        check("rt_done_once", 64'(done_cnt - s_done), 64'd1);

        // Zero-length start is ignored
        @(posedge clk);
        #1;
        s_done = done_cnt;
        start_clip(10, 0, 1'b0, 0);
        @(negedge clk);
        #1;
        check("len0_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("len0_no_done", 64'(done_cnt - s_done), 64'd0);

        // Start and stop together: stop wins
        @(posedge clk);
        #1;
        stop = 1'b1;
        start_clip(10, 3, 1'b0, 0);
        stop = 1'b0;
        @(negedge clk);
        #1;
        check("ss_busy", 64'(busy), 64'd0);

        // Reset mid-clip, then a fresh clip
        for (int i = 0; i < Depth; i++) mem[i] = DATA_W'($urandom);
        @(posedge clk);
        #1;
        qb = wq_data.size();
        start_clip(400, 6, 1'b0, 1);
        wait_writes("rm_reach", qb + 2);
        allow_mode = 3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rm_addr", 64'(ram_addr), 64'd0);
        check("rm_write", 64'(write_audio_out), 64'd0);
        check("rm_left", 64'(left), 64'd0);
        check("rm_right", 64'(right), 64'd0);
        check("rm_busy", 64'(busy), 64'd0);
        check("rm_done", 64'(done), 64'd0);
        allow_mode = 0;
        b = $urandom_range(0, Depth - 1);
        l = $urandom_range(1, 5);
        r = $urandom_range(0, 2);
        @(posedge clk);
        #1;
        qb = wq_data.size();
        s_done = done_cnt;
        start_clip(b, l, 1'b0, r);
        wait_idle("rm2_finish");
        ref_clip(b, l, r, l * (r + 1));
        cmp_clip("rm2", qb, l * (r + 1), 1'b1);
        check("rm2_latency", 64'(wq_cyc[qb] - start_cyc), 64'(2 + RAM_LAT));
        check("rm2_done", 64'(done_cnt - s_done), 64'd1);

        // Random one-shot clips under random handshake
        allow_mode = 2;
        for (int t = 0; t < 4; t++) begin
            b = $urandom_range(0, Depth - 1);
            l = $urandom_range(1, 6);
            r = $urandom_range(0, 3);
            @(posedge clk);
            #1;
            qb = wq_data.size();
            s_done = done_cnt;
            start_clip(b, l, 1'b0, r);
            wait_idle($sformatf("rnd%0d_finish", t));
            ref_clip(b, l, r, l * (r + 1));
            cmp_clip($sformatf("rnd%0d", t), qb, l * (r + 1), 1'b1);
            check($sformatf("rnd%0d_done", t), 64'(done_cnt - s_done), 64'd1);
        end

        check("all_allowed_only", 64'(viol), 64'd0);
        check("all_chan_equal", 64'(chan_mis), 64'd0);
        check("all_done_not_busy", 64'(done_busy), 64'd0);
        check("all_idle_zero", 64'(idle_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
